// File: rtl/key_debounce_cnt.sv
// -----------------------------------------------------------------------------
// key_debounce_cnt
//
// Push-button conditioner. The raw button level is synchronised into the clk
// domain and debounced by a four-state FSM (IDLE, PRESS_CHK, HELD, REL_CHK)
// that shares one stability counter between the press and the release checks.
// Every accepted press advances a two-digit BCD press counter.
//
// Optional feature (macro KEY_LONG_PRESS_EN):
//   defined   : a hold counter runs while the key is HELD and fires key_long
//               once per press after LONG_CYCLES held cycles.
//   undefined : no hold counter is built and key_long is tied low.
//   The port list is the same in both builds.
//
// Parameters
//   DEB_CYCLES  : stable cycles required to accept a press or a release
//   LONG_CYCLES : held cycles before key_long fires (macro build only)
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   button      : raw, bouncing, asynchronous push-button level
//   cnt_clr     : synchronous clear of press_cnt (wins over a press)
//   key_level   : debounced level, 1 in HELD and REL_CHK
//   key_pulse   : one-cycle pulse on an accepted press
//   key_release : one-cycle pulse on an accepted release
//   key_long    : one-cycle pulse on a long press
//   press_cnt   : BCD press count, [7:4] tens, [3:0] units
// -----------------------------------------------------------------------------
module key_debounce_cnt #(
  parameter int DEB_CYCLES  = 50000,
  parameter int LONG_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  input  logic       cnt_clr,
  output logic       key_level,
  output logic       key_pulse,
  output logic       key_release,
  output logic       key_long,
  output logic [7:0] press_cnt
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // Both thresholds are counts of cycles and must be at least one.
  if (DEB_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
    $error("key_debounce_cnt: DEB_CYCLES and LONG_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  state_t           state;
  logic [DEB_W-1:0] deb_cnt;
  logic             sync_ff;
  logic             btn_s;

  // One BCD step with 99 -> 00 wrap. A nibble above 9 is treated as 9 so
  // the counter always falls back into legal BCD on its next step.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (units >= 4'd9) begin
      units = 4'd0;
      tens  = (tens >= 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync_ff <= button;
      btn_s   <= sync_ff;
    end
  end

  // Debounce FSM. key_level changes on the same edge as the HELD / IDLE
  // transition, so it always matches the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      key_level   <= 1'b0;
      key_pulse   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_pulse   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          deb_cnt <= '0;
          if (btn_s) state <= PRESS_CHK;
        end
        PRESS_CHK: begin
          if (!btn_s) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= HELD;
            deb_cnt   <= '0;
            key_pulse <= 1'b1;
            key_level <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        HELD: begin
          deb_cnt <= '0;
          if (!btn_s) state <= REL_CHK;
        end
        REL_CHK: begin
          if (btn_s) begin
            // Release bounce: back to HELD without any pulse.
            state   <= HELD;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            key_release <= 1'b1;
            key_level   <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          deb_cnt <= '0;
        end
      endcase
    end
  end

  // Press counter advances on the edge where key_pulse is high, so a clear
  // presented in the key_pulse cycle meets the increment and wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_cnt <= 8'h00;
    end else if (cnt_clr) begin
      press_cnt <= 8'h00;
    end else if (key_pulse) begin
      press_cnt <= bcd_inc(press_cnt);
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] hold_cnt;
  logic              long_done;

  // hold_cnt saturates at LONG_LAST. long_done is only re-armed in IDLE,
  // so a REL_CHK bounce back into HELD cannot fire a second key_long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      long_done <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (state == HELD) begin
        if (hold_cnt == LONG_LAST) begin
          if (!long_done) begin
            key_long  <= 1'b1;
            long_done <= 1'b1;
          end
        end else begin
          hold_cnt <= hold_cnt + LONG_W'(1);
        end
      end else begin
        hold_cnt <= '0;
        if (state == IDLE) long_done <= 1'b0;
      end
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_cnt.sv
module tb_key_debounce_cnt;

  localparam int D = 8;
  localparam int L = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       key_level;
  logic       key_pulse;
  logic       key_release;
  logic       key_long;
  logic [7:0] press_cnt;

  always #5 clk = ~clk;

  key_debounce_cnt #(.DEB_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (button),
    .cnt_clr    (cnt_clr),
    .key_level  (key_level),
    .key_pulse  (key_pulse),
    .key_release(key_release),
    .key_long   (key_long),
    .press_cnt  (press_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int pulse_total = 0;
  int rel_total   = 0;
  int long_total  = 0;

  // Count high cycles of each pulse output; with one-cycle pulses this equals
  // the number of pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_pulse)   pulse_total++;
      if (key_release) rel_total++;
      if (key_long)    long_total++;
    end
  end

  typedef struct {
    logic       btn;
    int         cycles;
    int         exp_pulse;
    int         exp_rel;
    logic [7:0] exp_cnt;
    logic       exp_lvl;
  } vec_t;

  vec_t tbl[11];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig_by(input int which);
    case (which)
      0:       return key_pulse;
      1:       return key_release;
      default: return key_long;
    endcase
  endfunction

  // Ticks until the selected output is seen high; -1 on timeout.
  task automatic wait_sig(input int which, input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (sig_by(which)) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'((n / 10) % 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  task automatic press_release();
    button = 1'b1;
    ticks(D + 6);
    button = 1'b0;
    ticks(D + 6);
  endtask

  initial begin
    int bp, br, bl, lat;

    tbl[0]  = '{1'b0, 10, 0, 0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1,  3, 0, 0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 20, 0, 0, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 20, 1, 0, 8'h01, 1'b1};
    tbl[4]  = '{1'b0,  3, 1, 0, 8'h01, 1'b1};
    tbl[5]  = '{1'b1, 20, 1, 0, 8'h01, 1'b1};
    tbl[6]  = '{1'b0, 20, 1, 1, 8'h01, 1'b0};
    tbl[7]  = '{1'b1,  8, 1, 1, 8'h01, 1'b0};
    tbl[8]  = '{1'b0, 20, 1, 1, 8'h01, 1'b0};
    tbl[9]  = '{1'b1,  9, 1, 1, 8'h01, 1'b0};
    tbl[10] = '{1'b0, 20, 2, 2, 8'h02, 1'b0};

    // Reset with the button toggling: nothing may leak through.
    ticks(3);
    button = 1'b1;
    ticks(5);
    check("rst_level", key_level, 0);
    check("rst_pulse", key_pulse, 0);
    check("rst_release", key_release, 0);
    check("rst_long", key_long, 0);
    check("rst_cnt", press_cnt, 8'h00);
    button = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    ticks(5);
    check("post_rst_level", key_level, 0);
    check("post_rst_cnt", press_cnt, 8'h00);
    check("post_rst_pulses", pulse_total, 0);

    // Table-driven level sequences.
    bp = pulse_total;
    br = rel_total;
    for (int v = 0; v < 11; v++) begin
      button = tbl[v].btn;
      ticks(tbl[v].cycles);
      check($sformatf("vec%0d_pulses", v), pulse_total - bp, tbl[v].exp_pulse);
      check($sformatf("vec%0d_releases", v), rel_total - br, tbl[v].exp_rel);
      check($sformatf("vec%0d_cnt", v), press_cnt, tbl[v].exp_cnt);
      check($sformatf("vec%0d_level", v), key_level, tbl[v].exp_lvl);
    end

    // Exact press / release latency and pulse width.
    button = 1'b1;
    wait_sig(0, 4 * D + 20, lat);
    check("pulse_latency", lat, D + 3);
    check("level_at_pulse", key_level, 1);
    tick();
    check("pulse_width", key_pulse, 0);
    ticks(3);
    check("cnt_after_press", press_cnt, 8'h03);
    button = 1'b0;
    wait_sig(1, 4 * D + 20, lat);
    check("release_latency", lat, D + 3);
    check("level_at_release", key_level, 0);
    tick();
    check("release_width", key_release, 0);

    // Five bounces at onset and at release.
    bp = pulse_total;
    br = rel_total;
    for (int b = 0; b < 5; b++) begin
      button = 1'b1; ticks(2);
      button = 1'b0; ticks(2);
    end
    button = 1'b1;
    ticks(D + 12);
    for (int b = 0; b < 5; b++) begin
      button = 1'b0; ticks(2);
      button = 1'b1; ticks(2);
    end
    button = 1'b0;
    ticks(D + 12);
    check("bounce_pulses", pulse_total - bp, 1);
    check("bounce_releases", rel_total - br, 1);
    check("bounce_cnt", press_cnt, 8'h04);

    // Standalone clear.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt", press_cnt, 8'h00);

    // 100 presses: decimal model, with the 09->10 and 99->00 carries.
    for (int k = 1; k <= 100; k++) begin
      press_release();
      if (k == 10)       check("cnt_09_to_10", press_cnt, 8'h10);
      else if (k == 100) check("cnt_99_to_00", press_cnt, 8'h00);
      else               check($sformatf("cnt_press%0d", k), press_cnt, to_bcd(k % 100));
    end

    // Clear in the same cycle as key_pulse.
    press_release();
    check("pre_clr_cnt", press_cnt, 8'h01);
    button = 1'b1;
    wait_sig(0, 4 * D + 20, lat);
    check("clr_pulse_seen", lat, D + 3);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_beats_pulse", press_cnt, 8'h00);
    button = 1'b0;
    ticks(D + 12);

    // Asynchronous reset while HELD: outputs drop with no clock edge.
    press_release();
    button = 1'b1;
    ticks(D + 8);
    check("held_level", key_level, 1);
    check("held_cnt", press_cnt, 8'h02);
    rst_n = 1'b0;
    #1;
    check("async_rst_level", key_level, 0);
    check("async_rst_cnt", press_cnt, 8'h00);
    button = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    bp = pulse_total;
    br = rel_total;
    ticks(D + 12);
    check("after_rst_pulses", pulse_total - bp, 0);
    check("after_rst_releases", rel_total - br, 0);

    // Reset in PRESS_CHK discards the press.
    button = 1'b1;
    ticks(5);
    rst_n = 1'b0;
    ticks(2);
    button = 1'b0;
    rst_n = 1'b1;
    bp = pulse_total;
    ticks(D + 12);
    check("midpress_rst_pulses", pulse_total - bp, 0);
    check("midpress_rst_cnt", press_cnt, 8'h00);

    // Long press.
    bl = long_total;
    button = 1'b1;
    wait_sig(0, 4 * D + 20, lat);
    check("long_press_accept", lat, D + 3);
`ifdef KEY_LONG_PRESS_EN
    wait_sig(2, L + 20, lat);
    check("long_latency", lat, L);
    tick();
    check("long_width", key_long, 0);
    button = 1'b0;
    ticks(2);
    button = 1'b1;
    ticks(L + 20);
    button = 1'b0;
    ticks(D + 12);
    check("long_once_per_press", long_total - bl, 1);
`else
    ticks(L + 20);
    button = 1'b0;
    ticks(D + 12);
    check("long_tied_low", long_total - bl, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce_cnt.md
KEY_DEBOUNCE_CNT -- requirements
Module: key_debounce_cnt

Interface
REQ-001 Parameter DEB_CYCLES, default 50000; number of stable cycles required to accept an edge (0.5 ms at 100 MHz).
REQ-002 Parameter LONG_CYCLES, default 100000000; held-cycles threshold for long press (1 s at 100 MHz), used only under the macro in REQ-024.
REQ-003 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 button  input  1  raw push-button level, asynchronous, bouncing.
REQ-006 cnt_clr  input  1  synchronous clear of press_cnt, clk domain.
REQ-007 key_level  output  1  debounced button level.
REQ-008 key_pulse  output  1  one-cycle pulse on accepted press.
REQ-009 key_release  output  1  one-cycle pulse on accepted release.
REQ-010 key_long  output  1  one-cycle pulse on long press.
REQ-011 press_cnt  output  8  two-digit BCD press count: [7:4] tens, [3:0] units; feeds the display controller switch/digit inputs.

Function
REQ-012 button SHALL pass through a 2-flop synchronizer to btn_s before any use; synchronizer latency is 2 cycles.
REQ-013 FSM states SHALL be IDLE, PRESS_CHK, HELD, REL_CHK, with one shared counter deb_cnt sized ceil(log2(DEB_CYCLES)).
REQ-014 IDLE: on btn_s=1, go to PRESS_CHK with deb_cnt=0; otherwise stay.
REQ-015 PRESS_CHK: if btn_s=0, go to IDLE and clear deb_cnt; if deb_cnt=DEB_CYCLES-1, go to HELD and assert key_pulse for exactly that one cycle; otherwise increment deb_cnt.
REQ-016 HELD: on btn_s=0, go to REL_CHK with deb_cnt=0.
REQ-017 REL_CHK: if btn_s=1, return to HELD (no pulse); if deb_cnt=DEB_CYCLES-1, go to IDLE and assert key_release for one cycle; otherwise increment.
REQ-018 key_level SHALL be 1 in HELD and REL_CHK, 0 in IDLE and PRESS_CHK, registered.
REQ-019 press_cnt SHALL increment by one BCD step on each key_pulse:
- units 9 -> 0 with tens carry
- 99 -> 00 wrap
- never holds a non-BCD nibble
REQ-020 cnt_clr=1 SHALL set press_cnt to 00 on the next edge, taking priority over a simultaneous key_pulse.
REQ-021 Any btn_s pulse shorter than DEB_CYCLES cycles SHALL produce no key_pulse, key_release or count change.
REQ-022 Each accepted press SHALL produce exactly one key_pulse and one key_release, regardless of bounce count.

Reset
REQ-023 While rst_n=0, all of the following SHALL be forced immediately, independent of clk:
- FSM=IDLE, deb_cnt=0, synchronizer flops=0
- key_level=0, key_pulse=0, key_release=0, key_long=0
- press_cnt=8'h00
- Reset mid-press discards the press with no pulse.

Configuration
REQ-024 Macro KEY_LONG_PRESS_EN:
- Defined: a hold counter runs in HELD only and clears on leaving HELD. key_long pulses one cycle when the counter reaches LONG_CYCLES-1, at most once per press; REL_CHK bounces back to HELD do not re-arm it.
- Undefined: no hold counter is built, and key_long is tied to 0.
- The port list is identical in both cases.

Verification
REQ-025 rst_n=0 for 1 ms, button=0 -> all outputs 0, press_cnt=00; rst_n released -> outputs unchanged.
REQ-026 button high for 10 ns, then low -> no key_pulse and press_cnt stays 00.
REQ-027 button high 1 ms -> key_pulse exactly one cycle, 50002 ±1 cycles after the rise; key_level=1; press_cnt=01. Release -> key_release one cycle about 50002 cycles later.
REQ-028 Press with 5 bounces of 1 µs at onset and release -> exactly one key_pulse, one key_release, press_cnt +1.
REQ-029 100 accepted presses from 00 -> press_cnt passes 09->10 and 99->00. cnt_clr asserted in the same cycle as a key_pulse -> press_cnt=00.
REQ-030 With KEY_LONG_PRESS_EN and LONG_CYCLES=200000, hold button 3 ms -> one key_long 200000 cycles after HELD entry. Without the macro -> key_long stays 0.
